// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: drives every input vector of an N-input combinational
// gate, holds each for HOLD_CYCLES, samples the gate output on the last hold
// cycle and compares it against the EXPECTED truth table. Reports pass/fail,
// mismatch count and the lowest failing vector.
module gate_sweep_checker #(
  parameter int                          N_INPUTS    = 3,
  parameter int                          HOLD_CYCLES = 4,
  parameter logic [(2**N_INPUTS)-1:0]    EXPECTED    = 8'b1000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  dut_o,
  output logic [N_INPUTS-1:0]   stim,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [N_INPUTS:0]     err_count,
  output logic                  fail_valid,
  output logic [N_INPUTS-1:0]   first_fail
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [7:0]          HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] VEC_LAST  = '1;

  logic [1:0]          state_q, state_d;
  logic [N_INPUTS-1:0] stim_q, stim_d;
  logic [7:0]          hold_q, hold_d;
  logic [N_INPUTS:0]   err_q, err_d;
  logic                fv_q, fv_d;
  logic [N_INPUTS-1:0] ff_q, ff_d;
  logic                pass_q, pass_d;

  logic sample;
  logic mismatch;

  // Compare happens on the last hold cycle of the current vector.
  assign sample   = (state_q == S_RUN) && (hold_q == HOLD_LAST);
  assign mismatch = (dut_o != EXPECTED[stim_q]);

  // Next-state: sweep sequencing, result accumulation and verdict.
  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    hold_d  = hold_q;
    err_d   = err_q;
    fv_d    = fv_q;
    ff_d    = ff_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          stim_d  = '0;
          hold_d  = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          ff_d    = '0;
          pass_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (sample) begin
          if (mismatch) begin
            err_d = err_q + 1'b1;
            if (!fv_q) begin
              ff_d = stim_q;
              fv_d = 1'b1;
            end
          end
          // Incrementing the all-ones vector wraps stim to 0 on exit.
          stim_d = stim_q + 1'b1;
          hold_d = '0;
          if (stim_q == VEC_LAST) begin
            state_d = S_DONE;
            // Verdict includes the mismatch of the final vector.
            pass_d  = (err_d == '0);
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset discards any partial sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      stim_q  <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ff_q    <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
      pass_q  <= pass_d;
    end
  end

  assign stim       = stim_q;
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign first_fail = ff_q;

endmodule
